// File: rtl/imsic_msi_receiver.sv
// Single-hart IMSIC interrupt file: AXI-lite MSI writes latch pending IDs.
// Reports the lowest pending, enabled, under-threshold ID to the hart.
module imsic_msi_receiver #(
  parameter int          NR_IDS         = 64,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter logic [11:0] SETEIPNUM_OFF  = 12'h000,
  localparam int         ID_W           = $clog2(NR_IDS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] i_awaddr,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [31:0]               i_wdata,
  input  logic [3:0]                i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  input  logic [NR_IDS-1:0]         i_eie,
  input  logic [ID_W-1:0]           i_eithreshold,
  input  logic                      i_claim,
  output logic [ID_W-1:0]           o_topei,
  output logic                      o_xeip
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_W  = 2'd1;
  localparam logic [1:0] WAIT_AW = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state, state_nx;
  logic [11:0]       addr_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic [NR_IDS-1:0] eip;

  logic        aw_hs, w_hs, go_resp, commit;
  logic [11:0] addr_eff;
  logic [31:0] data_eff;
  logic [3:0]  strb_eff;
  logic [NR_IDS-1:0] set_vec, clr_vec;
  logic        unused_bits;

  assign unused_bits = ^{i_awaddr, i_eie[0]};

  assign o_awready = (state == IDLE) || (state == WAIT_AW);
  assign o_wready  = (state == IDLE) || (state == WAIT_W);
  assign o_bvalid  = (state == RESP);
  assign o_bresp   = 2'b00;

  assign aw_hs = i_awvalid && o_awready;
  assign w_hs  = i_wvalid && o_wready;

  // Use the live channel value when its handshake lands on the commit edge
  assign addr_eff = aw_hs ? i_awaddr[11:0] : addr_q;
  assign data_eff = w_hs ? i_wdata : data_q;
  assign strb_eff = w_hs ? i_wstrb : strb_q;

  // Handshake FSM next-state
  always_comb begin
    state_nx = state;
    go_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (aw_hs && w_hs) begin
          state_nx = RESP;
          go_resp  = 1'b1;
        end else if (aw_hs) begin
          state_nx = WAIT_W;
        end else if (w_hs) begin
          state_nx = WAIT_AW;
        end
      end
      WAIT_W: begin
        if (w_hs) begin
          state_nx = RESP;
          go_resp  = 1'b1;
        end
      end
      WAIT_AW: begin
        if (aw_hs) begin
          state_nx = RESP;
          go_resp  = 1'b1;
        end
      end
      RESP: begin
        if (i_bready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign commit = go_resp
               && (addr_eff == SETEIPNUM_OFF)
               && (strb_eff == 4'hF)
               && (data_eff != 32'd0)
               && (data_eff < 32'(NR_IDS));

  // Lowest-numbered deliverable ID wins
  always_comb begin
    o_topei = '0;
    for (int i = NR_IDS - 1; i >= 1; i--) begin
      if (eip[i] && i_eie[i] &&
          ((i_eithreshold == '0) || (ID_W'(i) < i_eithreshold)))
        o_topei = ID_W'(i);
    end
  end

  assign o_xeip = (o_topei != '0);

  // Set and claim-clear masks; set is applied last so it wins
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (commit) set_vec[data_eff[ID_W-1:0]] = 1'b1;
    if (i_claim && o_xeip) clr_vec[o_topei] = 1'b1;
  end

  // State, captured channel values and pending bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      eip    <= '0;
    end else begin
      state <= state_nx;
      if (aw_hs) addr_q <= i_awaddr[11:0];
      if (w_hs) begin
        data_q <= i_wdata;
        strb_q <= i_wstrb;
      end
      eip <= (eip & ~clr_vec) | set_vec;
    end
  end

endmodule
